reaction_judge: RTL and testbench
=================================

Name: reaction_judge

Overview:
- Upstream stage of the score accumulator in the Blink game.
- Opens a reaction window when the game controller lights a target LED, then watches the player buttons.
- Classifies the result as hit (correct button, graded by speed), wrong press, or timeout.
- Drives the accumulator's LD/CLR/D inputs; D is 4-bit points added to the running score.

Parameters:
- WINDOW, 100: reaction window length in clk cycles (>= 2).
- FAST_LIM, 25: a press at window count < FAST_LIM scores 3.
- MID_LIM, 60: a press at count < MID_LIM (and >= FAST_LIM) scores 2; later presses score 1. Requires FAST_LIM < MID_LIM <= WINDOW.

Ports:
- clk  in  1  system clock, all logic on rising edge
- RST_N  in  1  asynchronous active-low reset
- START  in  1  one-cycle pulse: new game
- LIGHT  in  1  one-cycle pulse: target LED lit, open round
- TARGET  in  2  index of lit LED, sampled with LIGHT
- BTN  in  4  player buttons, already synchronized and debounced, level
- LD  out  1  one-cycle load pulse to accumulator
- CLR  out  1  one-cycle clear pulse to accumulator
- D  out  4  points for accumulator (valid when LD=1, else 0)
- HIT  out  1  one-cycle pulse: correct press
- MISS  out  1  one-cycle pulse: wrong press or timeout
- BUSY  out  1  high while a round is open

Behaviour:
- Reset (RST_N=0, async): state IDLE; LD, CLR, HIT, MISS, BUSY = 0; D = 0; count = 0. btn_q resets to 4'hF, so buttons held through reset never count as presses.
- Edge detection: btn_q <= BTN every cycle. rise = BTN & ~btn_q. Only rising edges are presses.
- All outputs are registered. Decisions made in cycle N appear on outputs in cycle N+1, for exactly one cycle.
- IDLE: BUSY = 0.
  - LIGHT: latch TARGET, count <= 0, go to OPEN.
  - Presses in IDLE are ignored.
- OPEN: BUSY = 1; count increments each cycle, starting at 0 in the first OPEN cycle.
  - rise == one-hot of latched TARGET: HIT, LD, D = points(count), go to IDLE.
  - rise nonzero and anything else (wrong button, or several buttons rising together): MISS, LD = 0, go to IDLE.
  - rise == 0 and count == WINDOW-1: timeout MISS, go to IDLE.
  - A press at count == WINDOW-1 beats the timeout.
  - LIGHT while in OPEN is ignored.
- points(k): 3 if k < FAST_LIM; 2 if k < MID_LIM; else 1.
- BUSY drops in the same cycle that HIT or MISS is asserted.
- START: highest priority in any state.
  - Aborts any open round; go to IDLE.
  - CLR = 1 on the next cycle; no LD, HIT or MISS from the aborted round.
  - START and LIGHT in the same cycle: LIGHT is dropped.
- LD and CLR are never high in the same cycle.

Optional Feature:
- Macro: STREAK_EN.
- Defined:
  - A 2-bit saturating streak counter increments on each HIT.
  - It clears on MISS, START or reset.
  - A HIT that occurs while streak == 3 (the 4th and later consecutive hits) adds +1 to points, so D max = 4.
- Undefined: no streak logic; D is always points(k).

Test Plan:
1. Hold BTN = 4'b0001 through reset, then release and re-press with no LIGHT -> LD, HIT, MISS, BUSY all stay 0.
2. START pulse at cycle S -> CLR = 1 only at S+1; LD = 0; D = 0.
3. LIGHT with TARGET = 2 at cycle L; BTN[2] rises at L+11 (count 10) -> at L+12: LD = 1, D = 3, HIT = 1, BUSY = 0. Repeat with the press at count 40 -> D = 2; at count 80 -> D = 1.
4. TARGET = 2; BTN[0] rises -> MISS = 1, LD = 0. BTN[2] and BTN[0] rise together -> MISS = 1, LD = 0.
5. LIGHT at L, no press -> MISS = 1 at L+101; BUSY high from L+1 to L+100. BTN[2] rising at L+100 (count 99) -> HIT with D = 1, no MISS.
6. START at count 30 of an open round -> CLR next cycle, no HIT/MISS. With STREAK_EN, 4 consecutive count-10 hits -> D = 3, 3, 3, 4.

Source files
------------

// File: rtl/reaction_judge.sv
// ---------------------------------------------------------------------------
// reaction_judge
//   Upstream stage of the Blink score accumulator. When the game controller
//   lights a target LED (LIGHT), a reaction window of WINDOW cycles opens.
//   The window closes on the first button press or when it times out. A
//   correct press is a hit and is graded by speed. A wrong press, or the
//   window running out, is a miss. START aborts everything and clears the
//   accumulator.
//
//   Optional feature (macro STREAK_EN): a 2-bit saturating hit-streak
//   counter. The 4th and later consecutive hits score one bonus point.
//
// Ports
//   clk    in   system clock, rising edge
//   RST_N  in   asynchronous active-low reset
//   START  in   one-cycle new-game pulse (highest priority)
//   LIGHT  in   one-cycle pulse: target LED lit, open a round
//   TARGET in   [1:0] index of the lit LED, sampled with LIGHT
//   BTN    in   [3:0] player buttons (synchronized, debounced, level)
//   LD     out  one-cycle accumulator load pulse
//   CLR    out  one-cycle accumulator clear pulse
//   D      out  [3:0] points to add (0 unless LD)
//   HIT    out  one-cycle pulse: correct press
//   MISS   out  one-cycle pulse: wrong press or timeout
//   BUSY   out  high while a round is open
// ---------------------------------------------------------------------------
module reaction_judge #(
  parameter int unsigned WINDOW   = 100,
  parameter int unsigned FAST_LIM = 25,
  parameter int unsigned MID_LIM  = 60
) (
  input  logic       clk,
  input  logic       RST_N,
  input  logic       START,
  input  logic       LIGHT,
  input  logic [1:0] TARGET,
  input  logic [3:0] BTN,
  output logic       LD,
  output logic       CLR,
  output logic [3:0] D,
  output logic       HIT,
  output logic       MISS,
  output logic       BUSY
);

  localparam int unsigned CW = (WINDOW > 2) ? $clog2(WINDOW) : 1;

  typedef enum logic {
    S_IDLE,
    S_OPEN
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic [CW-1:0]   r_count;
  logic [1:0]      r_target;
  logic [3:0]      r_btn_q;
  logic [3:0]      w_rise;
  logic [3:0]      w_tgt_oh;
  logic            w_last;
  logic            w_ld_nx;
  logic            w_clr_nx;
  logic            w_hit_nx;
  logic            w_miss_nx;
  logic [3:0]      w_d_nx;
  logic [3:0]      w_points;

  logic            r_ld;
  logic            r_clr;
  logic [3:0]      r_d;
  logic            r_hit;
  logic            r_miss;
  logic            r_busy;

`ifdef STREAK_EN
  logic [1:0]      r_streak;
`endif

  assign w_rise   = BTN & ~r_btn_q;
  assign w_tgt_oh = 4'b0001 << r_target;
  assign w_last   = (32'(r_count) == (WINDOW - 1));

  // Speed grade for the current window position.
  always_comb begin
    w_points = 4'd1;
    if (32'(r_count) < FAST_LIM)
      w_points = 4'd3;
    else if (32'(r_count) < MID_LIM)
      w_points = 4'd2;
  end

  // State register, plus the registered outputs and round bookkeeping.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_target <= '0;
      r_btn_q  <= '1;  // buttons held through reset are not presses
      r_ld     <= 1'b0;
      r_clr    <= 1'b0;
      r_d      <= '0;
      r_hit    <= 1'b0;
      r_miss   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_btn_q  <= BTN;
      r_ld     <= w_ld_nx;
      r_clr    <= w_clr_nx;
      r_d      <= w_d_nx;
      r_hit    <= w_hit_nx;
      r_miss   <= w_miss_nx;
      r_busy   <= (w_state_nx == S_OPEN);
      if (!START && r_state == S_IDLE && LIGHT) begin
        r_target <= TARGET;
        r_count  <= '0;
      end else if (r_state == S_OPEN) begin
        r_count  <= r_count + 1'b1;
      end
    end
  end

`ifdef STREAK_EN
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N)
      r_streak <= '0;
    else if (w_clr_nx || w_miss_nx)
      r_streak <= '0;
    else if (w_hit_nx && r_streak != 2'd3)
      r_streak <= r_streak + 1'b1;
  end
`endif

  // Next-state logic.
  always_comb begin
    w_state_nx = r_state;
    if (START) begin
      w_state_nx = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (LIGHT) w_state_nx = S_OPEN;
        S_OPEN: if (w_rise != '0 || w_last) w_state_nx = S_IDLE;
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  // Output decisions, registered above so they appear one cycle later.
  // A press on the last window cycle is checked before the timeout.
  always_comb begin
    w_ld_nx   = 1'b0;
    w_clr_nx  = 1'b0;
    w_hit_nx  = 1'b0;
    w_miss_nx = 1'b0;
    w_d_nx    = '0;
    if (START) begin
      w_clr_nx = 1'b1;
    end else if (r_state == S_OPEN) begin
      if (w_rise == w_tgt_oh) begin
        w_hit_nx = 1'b1;
        w_ld_nx  = 1'b1;
`ifdef STREAK_EN
        w_d_nx   = (r_streak == 2'd3) ? w_points + 4'd1 : w_points;
`else
        w_d_nx   = w_points;
`endif
      end else if (w_rise != '0) begin
        w_miss_nx = 1'b1;
      end else if (w_last) begin
        w_miss_nx = 1'b1;
      end
    end
  end

  assign LD   = r_ld;
  assign CLR  = r_clr;
  assign D    = r_d;
  assign HIT  = r_hit;
  assign MISS = r_miss;
  assign BUSY = r_busy;

endmodule

// File: tb/tb_reaction_judge.sv
// ---------------------------------------------------------------------------
// tb_reaction_judge
//   Directed self-checking bench for reaction_judge with default parameters
//   (WINDOW=100, FAST_LIM=25, MID_LIM=60). Inputs change 1 ns after a rising
//   edge, and outputs are sampled 1 ns after the following rising edge.
// ---------------------------------------------------------------------------
module tb_reaction_judge;

  logic       clk;
  logic       RST_N;
  logic       START;
  logic       LIGHT;
  logic [1:0] TARGET;
  logic [3:0] BTN;
  logic       LD;
  logic       CLR;
  logic [3:0] D;
  logic       HIT;
  logic       MISS;
  logic       BUSY;

  int n_checks;
  int n_errors;

  reaction_judge #(
    .WINDOW   (100),
    .FAST_LIM (25),
    .MID_LIM  (60)
  ) u_dut (
    .clk    (clk),
    .RST_N  (RST_N),
    .START  (START),
    .LIGHT  (LIGHT),
    .TARGET (TARGET),
    .BTN    (BTN),
    .LD     (LD),
    .CLR    (CLR),
    .D      (D),
    .HIT    (HIT),
    .MISS   (MISS),
    .BUSY   (BUSY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Open a round, wait until window count cnt, drive pat, then check the
  // registered verdict on the next cycle.
  task automatic do_round(input string tag, input logic [1:0] tgt,
                          input int cnt, input logic [3:0] pat,
                          input logic exp_hit, input logic [3:0] exp_d);
    TARGET = tgt;
    LIGHT  = 1'b1;
    tick();
    LIGHT  = 1'b0;
    check({tag, "_busy_open"}, BUSY, 1);
    repeat (cnt) tick();
    BTN = pat;
    tick();
    check({tag, "_hit"},  HIT,  exp_hit);
    check({tag, "_miss"}, MISS, !exp_hit);
    check({tag, "_ld"},   LD,   exp_hit);
    check({tag, "_d"},    D,    exp_hit ? exp_d : 4'd0);
    check({tag, "_busy"}, BUSY, 0);
    BTN = 4'b0000;
    tick();
    check({tag, "_pulse_end"}, {LD, HIT, MISS, BUSY}, 0);
  endtask

  int         miss_cnt;
  logic [3:0] d4;

  initial begin
    n_checks = 0;
    n_errors = 0;
    RST_N  = 1'b0;
    START  = 1'b0;
    LIGHT  = 1'b0;
    TARGET = 2'd0;
    BTN    = 4'b0001;

    // 1: reset state, and a button held through reset is not a press.
    #12;
    check("rst_out", {LD, CLR, HIT, MISS, BUSY}, 0);
    check("rst_d", D, 0);
    @(negedge clk);
    RST_N = 1'b1;
    tick();
    tick();
    check("held_btn", {LD, HIT, MISS, BUSY}, 0);
    BTN = 4'b0000;
    tick();
    BTN = 4'b0001;
    tick();
    tick();
    check("idle_press", {LD, HIT, MISS, BUSY}, 0);
    BTN = 4'b0000;
    tick();

    // 2: START gives a single CLR pulse.
    START = 1'b1;
    tick();
    START = 1'b0;
    check("start_clr", CLR, 1);
    check("start_ld_d", {LD, D}, 0);
    tick();
    check("start_clr_end", CLR, 0);

    // 3: speed grading.
    do_round("fast", 2'd2, 10, 4'b0100, 1'b1, 4'd3);
    do_round("mid",  2'd2, 40, 4'b0100, 1'b1, 4'd2);
    do_round("slow", 2'd2, 80, 4'b0100, 1'b1, 4'd1);
    do_round("edge_fast", 2'd1, 24, 4'b0010, 1'b1, 4'd3);
    do_round("edge_mid",  2'd3, 25, 4'b1000, 1'b1, 4'd2);
    do_round("edge_slow", 2'd0, 60, 4'b0001, 1'b1, 4'd1);

    // 4: wrong button and multiple buttons.
    do_round("wrong", 2'd2, 5, 4'b0001, 1'b0, 4'd0);
    do_round("multi", 2'd2, 5, 4'b0101, 1'b0, 4'd0);

    // 5: timeout, and a press on the last window cycle.
    TARGET = 2'd2;
    LIGHT  = 1'b1;
    tick();
    LIGHT  = 1'b0;
    check("to_busy_first", BUSY, 1);
    repeat (99) tick();
    check("to_busy_last", {BUSY, MISS}, 2'b10);
    tick();
    check("to_miss", MISS, 1);
    check("to_busy_drop", {BUSY, LD, HIT}, 0);
    tick();
    check("to_miss_end", MISS, 0);
    do_round("last_cycle", 2'd2, 99, 4'b0100, 1'b1, 4'd1);

    // LIGHT while open does not restart the window.
    TARGET = 2'd1;
    LIGHT  = 1'b1;
    tick();
    repeat (50) tick();
    TARGET = 2'd3;
    tick();
    LIGHT  = 1'b0;
    repeat (48) tick();
    check("relight_busy", BUSY, 1);
    tick();
    check("relight_timeout", MISS, 1);
    tick();

    // 6: START aborts an open round.
    TARGET = 2'd2;
    LIGHT  = 1'b1;
    tick();
    LIGHT  = 1'b0;
    repeat (30) tick();
    START = 1'b1;
    tick();
    START = 1'b0;
    check("abort_clr", CLR, 1);
    check("abort_quiet", {LD, HIT, MISS, BUSY}, 0);
    miss_cnt = 0;
    for (int i = 0; i < 90; i++) begin
      tick();
      if (MISS || BUSY) miss_cnt++;
    end
    check("abort_no_timeout", miss_cnt, 0);

    // START and LIGHT together: LIGHT is dropped.
    TARGET = 2'd0;
    START  = 1'b1;
    LIGHT  = 1'b1;
    tick();
    START  = 1'b0;
    LIGHT  = 1'b0;
    check("start_light_clr", CLR, 1);
    check("start_light_busy", BUSY, 0);
    tick();
    check("start_light_idle", BUSY, 0);

    // Consecutive hits: the 4th scores a bonus only with STREAK_EN.
`ifdef STREAK_EN
    d4 = 4'd4;
`else
    d4 = 4'd3;
`endif
    do_round("streak1", 2'd2, 10, 4'b0100, 1'b1, 4'd3);
    do_round("streak2", 2'd2, 10, 4'b0100, 1'b1, 4'd3);
    do_round("streak3", 2'd2, 10, 4'b0100, 1'b1, 4'd3);
    do_round("streak4", 2'd2, 10, 4'b0100, 1'b1, d4);
    do_round("streak5", 2'd2, 10, 4'b0100, 1'b1, d4);
    do_round("streak_brk", 2'd2, 10, 4'b0001, 1'b0, 4'd0);
    do_round("streak_new", 2'd2, 10, 4'b0100, 1'b1, 4'd3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
